// File: rtl/blackjack_pkg.sv
// Shared types for the blackjack dealing path: card encoding, arbiter states,
// hand identifiers and the arbitration rule between the two hands.
package blackjack_pkg;

    // [6:5] suit, [4] unused, [3:0] value 1..11
    typedef logic [6:0] card_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } arb_state_e;

    typedef enum logic {
        PLAYER = 1'b0,
        DEALER = 1'b1
    } who_e;

    // When both hands are waiting, the one not served last goes next.
    function automatic who_e pick_grantee(
        input logic pend_player,
        input logic pend_dealer,
        input who_e last_grant
    );
        who_e pick;
        if (pend_player && pend_dealer) begin
            if (last_grant == PLAYER) pick = DEALER;
            else                      pick = PLAYER;
        end else if (pend_player) begin
            pick = PLAYER;
        end else begin
            pick = DEALER;
        end
        return pick;
    endfunction

endpackage

// File: rtl/deal_arbiter.sv
// Arbitrates single-card requests from the player and dealer hands onto one
// card_draw port, with a draw timeout that keeps the request for a retry.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no draw in flight; waits for deck loaded and a pending hand
//   ISSUE   | draw_req high for this single cycle, wait counter cleared
//   WAIT    | waiting for card_ready; aborts after TIMEOUT_CYCLES cycles
//   DELIVER | grantee's valid high with card_out stable, flag released
module deal_arbiter
    import blackjack_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load_done,
    input  logic  req_player,
    input  logic  req_dealer,
    input  logic  clear,
    output logic  draw_req,
    input  logic  card_ready,
    input  card_t card_data_in,
    output card_t card_out,
    output logic  player_card_valid,
    output logic  dealer_card_valid,
    output logic  busy,
    output logic  timeout_err
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_e    state;
    who_e          grantee;
    who_e          last_grant;
    logic          pend_player;
    logic          pend_dealer;
    logic          load_done_q;
    logic [CW-1:0] wait_cnt;

    assign busy = (state != IDLE) || pend_player || pend_dealer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            grantee           <= DEALER;
            last_grant        <= DEALER;
            pend_player       <= 1'b0;
            pend_dealer       <= 1'b0;
            load_done_q       <= 1'b0;
            wait_cnt          <= '0;
            card_out          <= '0;
            draw_req          <= 1'b0;
            player_card_valid <= 1'b0;
            dealer_card_valid <= 1'b0;
            timeout_err       <= 1'b0;
        end else begin
            // Staged so a rising deck-ready issues with the same two-cycle
            // latency as a fresh request pulse.
            load_done_q <= load_done;

            if (clear) begin
                state             <= IDLE;
                last_grant        <= DEALER;
                pend_player       <= 1'b0;
                pend_dealer       <= 1'b0;
                wait_cnt          <= '0;
                draw_req          <= 1'b0;
                player_card_valid <= 1'b0;
                dealer_card_valid <= 1'b0;
                timeout_err       <= 1'b0;
            end else begin
                draw_req          <= 1'b0;
                player_card_valid <= 1'b0;
                dealer_card_valid <= 1'b0;

                if (req_player) pend_player <= 1'b1;
                if (req_dealer) pend_dealer <= 1'b1;

                case (state)
                    IDLE: begin
                        if (load_done_q && (pend_player || pend_dealer)) begin
                            grantee  <= pick_grantee(pend_player, pend_dealer, last_grant);
                            draw_req <= 1'b1;
                            state    <= ISSUE;
                        end
                    end

                    ISSUE: begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end

                    WAIT: begin
                        // A card arriving on the last allowed cycle still wins.
                        if (card_ready) begin
                            card_out <= card_data_in;
                            if (grantee == PLAYER) player_card_valid <= 1'b1;
                            else                   dealer_card_valid <= 1'b1;
                            state <= DELIVER;
                        end else if (wait_cnt == WAIT_LAST) begin
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + CW'(1);
                        end
                    end

                    DELIVER: begin
                        // A fresh request landing now keeps the flag set.
                        last_grant <= grantee;
                        if (grantee == PLAYER && !req_player) pend_player <= 1'b0;
                        if (grantee == DEALER && !req_dealer) pend_dealer <= 1'b0;
                        state <= IDLE;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/deal_arbiter.md
DEAL_ARBITER -- requirements
Module: deal_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles for card_ready before abort.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 load_done  input  1  deck loaded; no draw is issued while low.
REQ-005 req_player  input  1  one-cycle pulse: player hand requests one card.
REQ-006 req_dealer  input  1  one-cycle pulse: dealer hand requests one card.
REQ-007 clear  input  1  synchronous new-round clear.
REQ-008 draw_req  output  1  one-cycle pulse to card_draw requesting one card.
REQ-009 card_ready  input  1  one-cycle pulse from card_draw; card_data_in valid that cycle.
REQ-010 card_data_in  input  7  card: [6:5] suit, [3:0] value 1..11, [4] unused.
REQ-011 card_out  output  7  registered copy of the last delivered card.
REQ-012 player_card_valid  output  1  one-cycle pulse: card_out belongs to player.
REQ-013 dealer_card_valid  output  1  one-cycle pulse: card_out belongs to dealer.
REQ-014 busy  output  1  high when state != IDLE or any request is pending.
REQ-015 timeout_err  output  1  sticky: a draw timed out.

Function
REQ-016 Each requester SHALL have a 1-deep pending flag, set on its request pulse, cleared in DELIVER for that requester.
REQ-017 A request while its flag is already set SHALL be coalesced (no queueing).
REQ-018 A request in the same cycle its flag is cleared SHALL leave the flag set.
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, DELIVER.
REQ-020 IDLE -> ISSUE SHALL occur when load_done=1 and any flag is set, latching the grantee.
REQ-021 Single pending -> that requester wins; both pending -> requester not served last (last_grant) wins.
REQ-022 ISSUE SHALL assert draw_req for exactly one cycle, then go to WAIT.
REQ-023 From idle, draw_req SHALL be high in the second cycle after the request pulse cycle.
REQ-024 WAIT: card_ready=1 SHALL capture card_data_in into card_out and go to DELIVER.
REQ-025 DELIVER SHALL pulse the grantee's valid for one cycle with card_out stable, update last_grant, return to IDLE.
REQ-026 card_ready in cycle M (WAIT) -> valid pulse in cycle M+1; next draw_req no earlier than M+3.
REQ-027 card_ready outside WAIT SHALL be ignored; card_out unchanged.
REQ-028 Wait counter SHALL clear on WAIT entry and increment each WAIT cycle without card_ready.
REQ-029 Counter reaching TIMEOUT_CYCLES-1 without card_ready: set timeout_err, go to IDLE, keep the flag (retry).
REQ-030 card_ready in the same cycle as the timeout condition SHALL win (normal delivery, no error).
REQ-031 load_done falling SHALL not abort an issued draw; it only blocks new IDLE -> ISSUE.
REQ-032 clear SHALL, from any state: go to IDLE, clear both flags, the counter and timeout_err, set last_grant=DEALER, suppress valid pulses that cycle.
REQ-033 A request pulse coincident with clear SHALL be dropped.

Reset
REQ-034 rst low SHALL immediately force: state IDLE, flags 0, counter 0, last_grant DEALER, card_out 0, draw_req 0, both valids 0, timeout_err 0.
REQ-035 Reset mid-draw SHALL discard the in-flight card; no valid pulse follows the reset release.

Structure
REQ-036 The card_t (7-bit) typedef, arb_state_e enum and who_e {PLAYER, DEALER} SHALL live in shared blackjack_pkg.
REQ-037 The block SHALL be a single module with no sub-modules.

Verification
REQ-038 load_done=1, req_player at cycle 0, card_ready at cycle 4 with 7'b0100111 -> draw_req at cycle 2; player_card_valid at cycle 5; card_out=7'b0100111.
REQ-039 req_player and req_dealer in the same cycle after reset -> player served first, then dealer; exactly two draw_req pulses.
REQ-040 TIMEOUT_CYCLES=8, card_draw silent -> timeout_err=1 after 8 WAIT cycles; FSM reissues draw_req; next card delivered to same requester.
REQ-041 Requests with load_done=0 -> no draw_req, busy=1; load_done rises -> draw_req two cycles later.
REQ-042 clear asserted in WAIT with card_ready the same cycle -> no valid pulse, flags 0, busy=0 next cycle.
REQ-043 rst low in WAIT, released, card_ready pulse -> no valid pulse; card_out=0.
